// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : apb_pkg                                                   |
// | Purpose  : FSM encoding, register offsets and CTRL bit positions     |
// |            shared by the APB register bank.                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_e;

    localparam logic [3:0] OFF_CTRL     = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_COUNT    = 4'd2;
    localparam logic [3:0] OFF_SCRATCH0 = 4'd4;
    localparam logic [3:0] OFF_SCRATCH7 = 4'd11;

    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    function automatic logic is_scratch(input logic [3:0] off);
        return (off >= OFF_SCRATCH0) && (off <= OFF_SCRATCH7);
    endfunction

    function automatic logic is_reserved(input logic [3:0] off);
        return (off == 4'd3) || (off > OFF_SCRATCH7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_regbank_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: apb_slave_regbank_if                                      |
// | Purpose  : APB completer-side bus bundle with master/slave views.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface apb_slave_regbank_if;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface
`default_nettype wire

// File: rtl/apb_wrap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_wrap_counter                                          |
// | Purpose  : Free-running 32-bit counter with sticky wrap flag (W1C).  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module apb_wrap_counter (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en_i,
    input  wire logic        clr_i,
    output logic [31:0]      count_o,
    output logic             flag_o
);

    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        w_wrap;

    always_comb begin
        w_wrap  = en_i && (count_q == 32'hFFFF_FFFF);
        count_d = en_i ? count_q + 32'd1 : count_q;
        // A wrap on the same edge as a clear keeps the flag set.
        flag_d  = w_wrap ? 1'b1 : (clr_i ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o = count_q;
    assign flag_o  = flag_q;

endmodule
`default_nettype wire

// File: rtl/apb_slave_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : apb_slave_regbank                                         |
// | Purpose  : APB register bank: CTRL/STATUS/COUNT and 8 scratch regs   |
// |            with configurable wait states and error responses.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_CTRL  = 32'h0
) (
    input  wire logic           HCLK,
    input  wire logic           HRESET,
    apb_slave_regbank_if.slave  apb,
    output logic                IRQ
);

    localparam logic [2:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    apb_state_e  state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [5:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] scratch_q [8];
    logic [31:0] scratch_d [8];

    logic [3:0]  w_off;
    logic [2:0]  w_sidx;
    logic        w_access;
    logic        w_err;
    logic        w_do_write;
    logic        w_status_clr;
    logic [31:0] w_rdata;
    logic [31:0] w_count;
    logic        w_status;
    logic        w_unused_paddr;

    assign w_unused_paddr = ^apb.PADDR[31:6];

    assign w_off      = addr_q[5:2];
    assign w_sidx     = 3'(w_off - OFF_SCRATCH0);
    assign w_access   = (state_q == ST_ACCESS) && apb.PSEL;
    assign w_err      = (addr_q[1:0] != 2'b00) || is_reserved(w_off)
                      || (write_q && (w_off == OFF_COUNT));
    assign w_do_write = w_access && write_q && !w_err;
    assign w_status_clr = w_do_write && (w_off == OFF_STATUS) && wdata_q[0];

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:   w_rdata = {30'b0, ctrl_q};
            OFF_STATUS: w_rdata = {31'b0, w_status};
            OFF_COUNT:  w_rdata = w_count;
            default:    if (is_scratch(w_off)) w_rdata = scratch_q[w_sidx];
        endcase
    end

    assign apb.PREADY  = w_access;
    assign apb.PSLVERR = w_access && w_err;
    assign apb.PRDATA  = (w_access && !write_q && !w_err) ? w_rdata : 32'h0;
    assign IRQ         = w_status && ctrl_q[CTRL_IRQ_EN];

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;

        case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                // Transfer attributes are frozen here; later bus changes are ignored.
                addr_d  = apb.PADDR[5:0];
                write_d = apb.PWRITE;
                wdata_d = apb.PWDATA;
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (apb.PENABLE) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = C_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL)          state_d = ST_IDLE;
                else if (wcnt_q == 3'd0) state_d = ST_ACCESS;
                else                     wcnt_d  = wcnt_q - 3'd1;
            end
            ST_ACCESS: begin
                state_d = (apb.PSEL && !apb.PENABLE) ? ST_SETUP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_do_write) begin
            if (w_off == OFF_CTRL)   ctrl_d = wdata_q[1:0];
            if (is_scratch(w_off))   scratch_d[w_sidx] = wdata_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            ctrl_q    <= RESET_CTRL[1:0];
            scratch_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
        end
    end

    apb_wrap_counter u_counter (
        .clk     (HCLK),
        .rst     (HRESET),
        .en_i    (ctrl_q[CTRL_CNT_EN]),
        .clr_i   (w_status_clr),
        .count_o (w_count),
        .flag_o  (w_status)
    );

endmodule
`default_nettype wire

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, number of wait cycles (0-7) inserted in each ACCESS phase before PREADY.
REQ-002 SHALL have parameter RESET_CTRL, default 32'h0, reset value of the CTRL register.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 HCLK  input  1  system clock; all state updates on the rising edge.
REQ-005 HRESET  input  1  synchronous active-high reset.
REQ-006 PSEL  input  1  slave select, driven from one PSELSn output of the AHB-to-APB bridge.
REQ-007 PENABLE  input  1  APB access-phase strobe.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PADDR  input  32  byte address; only PADDR[5:0] is decoded.
REQ-010 PWDATA  input  32  write data.
REQ-011 PRDATA  output  32  read data; valid only when PREADY=1 and PWRITE=0, otherwise 0.
REQ-012 PREADY  output  1  access-phase completion.
REQ-013 PSLVERR  output  1  error response; valid only when PREADY=1, otherwise 0.
REQ-014 IRQ  output  1  level interrupt, STATUS[0] & CTRL[1].

Function
REQ-015 Register map by PADDR[5:2]: 0 CTRL (RW; bit0 count enable, bit1 IRQ enable, bits 31:2 read 0); 1 STATUS (bit0 sticky wrap flag, write-1-to-clear); 2 COUNT (RO); 4-11 SCRATCH0-7 (RW, 32-bit); 3 and 12-15 reserved.
REQ-016 FSM states: IDLE, SETUP, WAIT, ACCESS.
REQ-017 IDLE -> SETUP when PSEL=1 and PENABLE=0; PSEL=1 with PENABLE=1 in IDLE is a protocol violation, ignored, and the FSM stays in IDLE.
REQ-018 SETUP -> WAIT when PENABLE=1 and WAIT_STATES>0, loading the wait counter with WAIT_STATES-1; SETUP -> ACCESS when PENABLE=1 and WAIT_STATES=0.
REQ-019 WAIT decrements the wait counter each cycle and moves to ACCESS when the counter is 0; PREADY=0 throughout SETUP and WAIT.
REQ-020 PREADY=1 for exactly one cycle in ACCESS; the read or write takes effect on that cycle's edge; ACCESS -> SETUP if PSEL=1 and PENABLE=0 (back-to-back), otherwise ACCESS -> IDLE.
REQ-021 Total latency from the SETUP cycle to PREADY is WAIT_STATES+1 cycles.
REQ-022 PSEL=0 in SETUP, WAIT or ACCESS aborts the transfer: no register update, PREADY=0, next state IDLE.
REQ-023 PSLVERR=1 with PREADY and no register change for: a reserved offset; PADDR[1:0]!=0; a write to COUNT. Reads of reserved offsets return 0.
REQ-024 PADDR, PWRITE and PWDATA SHALL be sampled in SETUP and held internally; changes during WAIT/ACCESS are ignored.
REQ-025 COUNT is 32-bit, increments by 1 each cycle while CTRL[0]=1, and wraps from 32'hFFFF_FFFF to 0; the wrap sets STATUS[0].
REQ-026 If a wrap and a W1C clear of STATUS[0] occur on the same cycle, the set SHALL win.
REQ-027 A read of COUNT SHALL return the value present on the PREADY cycle.

Reset
REQ-028 HRESET=1 forces: FSM to IDLE, wait counter 0, CTRL=RESET_CTRL, STATUS=0, COUNT=0, SCRATCH0-7=0, PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no register update; HRESET has priority over all other events.

Structure
REQ-030 A shared package apb_pkg SHALL hold the FSM state encoding, the register offset constants, and the CTRL bit positions.
REQ-031 The free-running counter and its wrap flag SHALL be one sub-module, apb_wrap_counter; decode, FSM and the register file stay at top level.

Verification
REQ-032 WAIT_STATES=1: write 32'hC800_003F to offset 0x10, then read 0x10 -> PREADY exactly 2 cycles after each SETUP, PRDATA=32'hC800_003F, PSLVERR=0.
REQ-033 Read 0x0C and write 0x08 -> PSLVERR=1 on the PREADY cycle, PRDATA=0, COUNT unaffected.
REQ-034 Write COUNT preloaded near wrap via force, CTRL=3 -> at 0xFFFF_FFFF->0, STATUS[0]=1 and IRQ=1 the next cycle; W1C write to STATUS -> IRQ=0.
REQ-035 Drop PSEL during WAIT with WAIT_STATES=3 on a write of 32'hF000_0080 to 0x14 -> no PREADY, SCRATCH1 unchanged, FSM in IDLE.
REQ-036 Assert HRESET during ACCESS of a write to 0x18 -> all outputs 0 the next cycle, SCRATCH2=0; back-to-back transfers with WAIT_STATES=0 -> one PREADY every 2 cycles.
